// File: rtl/video_raster_timing_pkg.sv
// ============================================================================
// video_pkg : shared timing presets, colour width and pixel types for the
//             raster timing generator.
// Revision  : 1.0  initial release
// ============================================================================
`default_nettype none

package video_pkg;

   // 640x480@60 timing (25.175 MHz pixel clock)
   localparam int VGA_H_ACTIVE      = 640;
   localparam int VGA_H_FRONT_PORCH = 16;
   localparam int VGA_H_SYNC        = 96;
   localparam int VGA_H_BACK_PORCH  = 48;
   localparam int VGA_V_ACTIVE      = 480;
   localparam int VGA_V_FRONT_PORCH = 10;
   localparam int VGA_V_SYNC        = 2;
   localparam int VGA_V_BACK_PORCH  = 33;

   // 320x240 source shown line-doubled on the 640x480 raster
   localparam int QVGA_SRC_H_ACTIVE = 320;
   localparam int QVGA_SRC_V_ACTIVE = 240;
   localparam bit QVGA_LINE_DBL     = 1'b1;

   localparam int COLOR_W    = 4;
   localparam int LINE_IDX_W = 10;
   localparam int MAX_TOTAL  = 1024;

   typedef struct packed {
      logic [COLOR_W-1:0] r;
      logic [COLOR_W-1:0] g;
      logic [COLOR_W-1:0] b;
   } rgb_t;

   function automatic int total4(input int a, input int b, input int c, input int d);
      return a + b + c + d;
   endfunction

endpackage

`default_nettype wire

// File: rtl/video_delay_line.sv
// ============================================================================
// video_delay_line : DEPTH-stage shift register that advances only when en
//                    is high; clears to zero on reset.
// Revision         : 1.0  initial release
// ============================================================================
`default_nettype none

module video_delay_line
   import video_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
      end else if (en) begin
         r_stage[0] <= din;
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign dout = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/video_raster_timing.sv
// ============================================================================
// video_raster_timing : parametrised H/V raster timing, render strobes,
//                       line doubling and latency-aligned pixel output stage.
//                       Optional composite sync output: VIDEO_CSYNC_EN.
// Revision            : 1.0  initial release
// ============================================================================
`default_nettype none

module video_raster_timing
   import video_pkg::*;
#(
   parameter int H_ACTIVE      = video_pkg::VGA_H_ACTIVE,
   parameter int H_FRONT_PORCH = video_pkg::VGA_H_FRONT_PORCH,
   parameter int H_SYNC        = video_pkg::VGA_H_SYNC,
   parameter int H_BACK_PORCH  = video_pkg::VGA_H_BACK_PORCH,
   parameter int V_ACTIVE      = video_pkg::VGA_V_ACTIVE,
   parameter int V_FRONT_PORCH = video_pkg::VGA_V_FRONT_PORCH,
   parameter int V_SYNC        = video_pkg::VGA_V_SYNC,
   parameter int V_BACK_PORCH  = video_pkg::VGA_V_BACK_PORCH,
   parameter bit HSYNC_POL     = 1'b0,
   parameter bit VSYNC_POL     = 1'b0,
   parameter int COLOR_W       = video_pkg::COLOR_W,
   parameter int PIPE_DELAY    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   pix_en,
   input  logic                   line_dbl,
   input  logic [3*COLOR_W-1:0]   pixel_rgb_data,
   output logic                   next_pixel,
   output logic [LINE_IDX_W-1:0]  display_line_idx,
   output logic                   start_of_screen,
   output logic                   start_of_line,
   output logic                   end_of_screen,
   output logic [COLOR_W-1:0]     vga_r,
   output logic [COLOR_W-1:0]     vga_g,
   output logic [COLOR_W-1:0]     vga_b,
   output logic                   vga_hsync,
   output logic                   vga_vsync
`ifdef VIDEO_CSYNC_EN
   ,
   output logic                   vga_csync
`endif
);

   localparam int H_TOTAL  = total4(H_ACTIVE, H_FRONT_PORCH, H_SYNC, H_BACK_PORCH);
   localparam int V_TOTAL  = total4(V_ACTIVE, V_FRONT_PORCH, V_SYNC, V_BACK_PORCH);
   localparam int X_W      = $clog2(H_TOTAL);
   localparam int Y_W      = $clog2(V_TOTAL);
   localparam int HS_START = H_ACTIVE + H_FRONT_PORCH;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FRONT_PORCH;
   localparam int VS_END   = VS_START + V_SYNC;

   generate
      if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
         $error("video_raster_timing: H_TOTAL/V_TOTAL must not exceed 1024");
      end
      if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_delay
         $error("video_raster_timing: PIPE_DELAY must be in 1..8");
      end
   endgenerate

   logic [X_W-1:0]        r_x;
   logic [Y_W-1:0]        r_y;
   logic [LINE_IDX_W-1:0] r_line_idx;
   logic                  r_dbl_q;
   logic                  r_dbl_phase;

   logic w_h_last;
   logic w_v_last;
   logic w_sos;
   logic w_sol;
   logic w_eos;

   assign w_h_last = (r_x == X_W'(H_TOTAL - 1));
   assign w_v_last = (r_y == Y_W'(V_TOTAL - 1));
   assign w_sol    = pix_en && w_h_last;
   // Renderer gets one line of lead time before the first visible line
   assign w_sos    = w_sol && (r_y == Y_W'(V_TOTAL - 2));
   assign w_eos    = w_sol && (r_y == Y_W'(V_ACTIVE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x <= '0;
         r_y <= '0;
      end else if (pix_en) begin
         if (w_h_last) begin
            r_x <= '0;
            r_y <= w_v_last ? '0 : r_y + Y_W'(1);
         end else begin
            r_x <= r_x + X_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_line_idx  <= '0;
         r_dbl_q     <= 1'b0;
         r_dbl_phase <= 1'b0;
      end else if (w_sol) begin
         if (w_sos) begin
            r_line_idx  <= '0;
            r_dbl_q     <= line_dbl;
            r_dbl_phase <= 1'b0;
         end else if (!r_dbl_q) begin
            r_line_idx <= r_line_idx + LINE_IDX_W'(1);
         end else begin
            if (r_dbl_phase) r_line_idx <= r_line_idx + LINE_IDX_W'(1);
            r_dbl_phase <= ~r_dbl_phase;
         end
      end
   end

   logic       w_hsync_raw;
   logic       w_vsync_raw;
   logic       w_active;
   logic [2:0] w_pipe;

   assign w_hsync_raw = (r_x >= X_W'(HS_START)) && (r_x <= X_W'(HS_END - 1));
   assign w_vsync_raw = (r_y >= Y_W'(VS_START)) && (r_y <= Y_W'(VS_END - 1));
   assign w_active    = (r_x <= X_W'(H_ACTIVE - 1)) && (r_y <= Y_W'(V_ACTIVE - 1));

   video_delay_line #(
      .DEPTH (PIPE_DELAY),
      .WIDTH (3)
   ) u_align (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pix_en),
      .din   ({w_active, w_vsync_raw, w_hsync_raw}),
      .dout  (w_pipe)
   );

   logic               r_hsync;
   logic               r_vsync;
   logic [COLOR_W-1:0] r_r;
   logic [COLOR_W-1:0] r_g;
   logic [COLOR_W-1:0] r_b;

   // Pipeline carries active-high syncs; polarity is applied at the pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hsync <= ~HSYNC_POL;
         r_vsync <= ~VSYNC_POL;
         r_r     <= '0;
         r_g     <= '0;
         r_b     <= '0;
      end else if (pix_en) begin
         r_hsync <= ~(w_pipe[0] ^ HSYNC_POL);
         r_vsync <= ~(w_pipe[1] ^ VSYNC_POL);
         if (w_pipe[2]) begin
            r_r <= pixel_rgb_data[3*COLOR_W-1 -: COLOR_W];
            r_g <= pixel_rgb_data[2*COLOR_W-1 -: COLOR_W];
            r_b <= pixel_rgb_data[COLOR_W-1:0];
         end else begin
            r_r <= '0;
            r_g <= '0;
            r_b <= '0;
         end
      end
   end

`ifdef VIDEO_CSYNC_EN
   logic r_csync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_csync <= 1'b1;
      end else if (pix_en) begin
         r_csync <= ~(w_pipe[0] ^ w_pipe[1]);
      end
   end

   assign vga_csync = r_csync;
`endif

   assign next_pixel       = pix_en;
   assign display_line_idx = r_line_idx;
   assign start_of_screen  = w_sos;
   assign start_of_line    = w_sol;
   assign end_of_screen    = w_eos;
   assign vga_r            = r_r;
   assign vga_g            = r_g;
   assign vga_b            = r_b;
   assign vga_hsync        = r_hsync;
   assign vga_vsync        = r_vsync;

endmodule

`default_nettype wire
